acc_cpu_core: RTL and testbench

//  Parametrised multi-cycle accumulator CPU; next generation of the team's 8-bit accumulator core.

---
 rtl/acc_cpu_pkg.sv | 14 +
 rtl/acc_cpu_ram.sv | 18 +
 rtl/acc_cpu_core.sv | 163 ++++++++++++++++
 tb/tb_acc_cpu_core.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
// Opcode and FSM state encodings shared by the accumulator core and its bench.
package acc_cpu_pkg;
    localparam logic [3:0] OP_NOP = 4'h0, OP_LDA_I = 4'h1, OP_LDA_M = 4'h2, OP_STA = 4'h3;
    localparam logic [3:0] OP_ADD_I = 4'h4, OP_ADD_M = 4'h5, OP_SUB_I = 4'h6, OP_SUB_M = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8, OP_JZ = 4'h9, OP_JNZ = 4'hA, OP_IN = 4'hB;
    localparam logic [3:0] OP_OUT = 4'hC, OP_JC = 4'hD, OP_JNC = 4'hE, OP_HLT = 4'hF;

    localparam logic [2:0] ST_HALT = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_OPERAND = 3'd3;
    localparam logic [2:0] ST_MEMRD = 3'd4, ST_IN = 3'd5, ST_OUT = 3'd6;

    function automatic logic is_two_word(input logic [3:0] op);
        return ((op >= OP_LDA_I) && (op <= OP_JNZ)) || (op == OP_JC) || (op == OP_JNC);
    endfunction
endpackage

// File: rtl/acc_cpu_ram.sv
// Single-port RAM with one-cycle synchronous read; contents are never reset.
module acc_cpu_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: FSM, datapath and flags around a private unified RAM.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    input  logic [DATA_W-1:0] io_in_data,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    output logic [DATA_W-1:0] io_out_data,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic              halted,
    output logic              illegal
);
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO_A = ADDR_W'(2);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_acc, r_out_data;
    logic [3:0]        r_ir;
    logic              r_z, r_c, r_illegal;

    logic [DATA_W-1:0] w_rdata, w_ram_wdata, w_res;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W:0]   w_sum, w_diff;
    logic [3:0]        w_op;
    logic              w_ram_we, w_cout, w_take;

    acc_cpu_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .i_clk(clk), .i_we(w_ram_we), .i_addr(w_ram_addr),
        .i_wdata(w_ram_wdata), .o_rdata(w_rdata)
    );

    assign w_op         = w_rdata[3:0];
    assign halted       = (r_state == ST_HALT);
    assign illegal      = r_illegal;
    assign io_in_ready  = (r_state == ST_IN);
    assign io_out_valid = (r_state == ST_OUT);
    assign io_out_data  = r_out_data;

    // RAM data is the ALU operand in both OPERAND (immediate) and MEMRD (memory word).
    always_comb begin
        w_sum  = {1'b0, r_acc} + {1'b0, w_rdata};
        w_diff = {1'b0, r_acc} - {1'b0, w_rdata};
        w_res  = w_rdata;
        w_cout = r_c;
        case (r_ir)
            OP_ADD_I, OP_ADD_M: begin w_res = w_sum[DATA_W-1:0];  w_cout = w_sum[DATA_W];  end
            OP_SUB_I, OP_SUB_M: begin w_res = w_diff[DATA_W-1:0]; w_cout = w_diff[DATA_W]; end
            default: ;
        endcase
    end

    always_comb begin
        case (r_ir)
            OP_JMP:  w_take = 1'b1;
            OP_JZ:   w_take = r_z;
            OP_JNZ:  w_take = !r_z;
            OP_JC:   w_take = r_c;
            OP_JNC:  w_take = !r_c;
            default: w_take = 1'b0;
        endcase
    end

    // The program port only reaches the RAM while halted; otherwise the core owns it.
    always_comb begin
        w_ram_addr  = r_pc;
        w_ram_we    = 1'b0;
        w_ram_wdata = r_acc;
        case (r_state)
            ST_HALT: begin
                w_ram_addr  = prog_addr;
                w_ram_we    = prog_we;
                w_ram_wdata = prog_wdata;
            end
            ST_DECODE:  w_ram_addr = r_pc + ONE_A;
            ST_OPERAND: begin
                w_ram_addr = w_rdata[ADDR_W-1:0];
                w_ram_we   = (r_ir == OP_STA);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_HALT;
            r_pc       <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_ir       <= OP_NOP;
            r_z        <= 1'b1;
            r_c        <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                ST_HALT: if (start) begin
                    r_pc      <= '0;
                    r_illegal <= 1'b0;
                    r_state   <= ST_FETCH;
                end
                ST_FETCH: r_state <= ST_DECODE;
                ST_DECODE: begin
                    r_ir <= w_op;
                    if (w_rdata[DATA_W-1:4] != '0) begin
                        r_illegal <= 1'b1;
                        r_state   <= ST_HALT;
                    end else if (is_two_word(w_op)) begin
                        r_state <= ST_OPERAND;
                    end else begin
                        case (w_op)
                            OP_IN:  r_state <= ST_IN;
                            OP_OUT: begin r_out_data <= r_acc; r_state <= ST_OUT; end
                            OP_HLT: begin r_pc <= r_pc + ONE_A; r_state <= ST_HALT; end
                            default: begin r_pc <= r_pc + ONE_A; r_state <= ST_FETCH; end
                        endcase
                    end
                end
                ST_OPERAND: begin
                    r_pc    <= r_pc + TWO_A;
                    r_state <= ST_FETCH;
                    case (r_ir)
                        OP_LDA_I, OP_ADD_I, OP_SUB_I: begin
                            r_acc <= w_res;
                            r_z   <= (w_res == '0);
                            r_c   <= w_cout;
                        end
                        OP_LDA_M, OP_ADD_M, OP_SUB_M: r_state <= ST_MEMRD;
                        OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC:
                            if (w_take) r_pc <= w_rdata[ADDR_W-1:0];
                        default: ;
                    endcase
                end
                ST_MEMRD: begin
                    r_acc   <= w_res;
                    r_z     <= (w_res == '0);
                    r_c     <= w_cout;
                    r_state <= ST_FETCH;
                end
                ST_IN: if (io_in_valid) begin
                    r_acc   <= io_in_data;
                    r_z     <= (io_in_data == '0);
                    r_pc    <= r_pc + ONE_A;
                    r_state <= ST_FETCH;
                end
                ST_OUT: if (io_out_ready) begin
                    r_pc    <= r_pc + ONE_A;
                    r_state <= ST_FETCH;
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: ISA-level reference interpreter feeding an OUT scoreboard.
module tb_acc_cpu_core;
    import acc_cpu_pkg::*;

    logic       clk = 0, reset_n, start, prog_we;
    logic [7:0] prog_addr, prog_wdata, io_in_data, io_out_data;
    logic       io_in_valid, io_in_ready, io_out_valid, io_out_ready, halted, illegal;

    logic        b_start, b_prog_we, b_io_in_ready, b_io_out_valid, b_halted, b_illegal;
    logic [9:0]  b_prog_addr;
    logic [15:0] b_prog_wdata, b_io_out_data;
    logic        b_io_in_valid = 1'b0, b_io_out_ready = 1'b1;
    logic [15:0] b_io_in_data = '0;

    acc_cpu_core dut (
        .clk(clk), .reset_n(reset_n), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .io_in_data(io_in_data), .io_in_valid(io_in_valid),
        .io_in_ready(io_in_ready), .io_out_data(io_out_data), .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready), .halted(halted), .illegal(illegal)
    );

    acc_cpu_core #(.DATA_W(16), .ADDR_W(10)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(b_start), .prog_we(b_prog_we),
        .prog_addr(b_prog_addr), .prog_wdata(b_prog_wdata), .io_in_data(b_io_in_data),
        .io_in_valid(b_io_in_valid), .io_in_ready(b_io_in_ready), .io_out_data(b_io_out_data),
        .io_out_valid(b_io_out_valid), .io_out_ready(b_io_out_ready), .halted(b_halted),
        .illegal(b_illegal)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int img[256];
    int ram_exp[256];
    int exp_q[$], in_q[$];
    int m_acc = 0, m_z = 1, m_c = 0, m_pc = 0, m_ill = 0;
    int rdy_force = 1, in_dly_force = -1;
    bit in_took = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: run the program image instruction by instruction until HLT/illegal.
    function automatic bit model_exec();
        int mm[256];
        int eq[$], iq[$];
        int acc, z, c, pc, nxt, w, op, opd, v, s;
        bit done;
        mm = img; acc = m_acc; z = m_z; c = m_c; pc = 0; done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            w = mm[pc]; op = w % 16; opd = mm[(pc + 1) % 256];
            nxt = (pc + 2) % 256;
            if (w > 15) begin
                m_ill = 1; m_pc = pc; done = 1;
            end else begin
                case (op)
                    0: nxt = (pc + 1) % 256;
                    1, 2: begin acc = (op == 1) ? opd : mm[opd]; z = (acc == 0); end
                    3: mm[opd] = acc;
                    4, 5: begin
                        v = (op == 4) ? opd : mm[opd];
                        s = acc + v; c = (s > 255); acc = s % 256; z = (acc == 0);
                    end
                    6, 7: begin
                        v = (op == 6) ? opd : mm[opd];
                        c = (acc < v); acc = (acc - v + 256) % 256; z = (acc == 0);
                    end
                    8:  nxt = opd;
                    9:  if (z != 0) nxt = opd;
                    10: if (z == 0) nxt = opd;
                    13: if (c != 0) nxt = opd;
                    14: if (c == 0) nxt = opd;
                    11: begin
                        v = $urandom_range(0, 255); iq.push_back(v);
                        acc = v; z = (acc == 0); nxt = (pc + 1) % 256;
                    end
                    12: begin eq.push_back(acc); nxt = (pc + 1) % 256; end
                    default: begin m_ill = 0; m_pc = (pc + 1) % 256; done = 1; end
                endcase
                pc = nxt;
            end
        end
        if (!done) return 1'b0;
        m_acc = acc; m_z = z; m_c = c; ram_exp = mm;
        foreach (eq[i]) exp_q.push_back(eq[i]);
        foreach (iq[i]) in_q.push_back(iq[i]);
        return 1'b1;
    endfunction

    // Scoreboard monitor: compare every OUT transfer against the model's queue.
    initial forever begin
        @(negedge clk);
        in_took = io_in_valid && io_in_ready;
        if (io_out_valid && io_out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: got %0h want none", io_out_data);
            end else begin
                int e;
                e = exp_q.pop_front();
                if ({24'b0, io_out_data} !== e) begin
                    bad++;
                    $display("FAIL out_data: got %0h want %0h", io_out_data, e);
                end
            end
        end
    end

    initial begin
        io_out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_force)
                1: io_out_ready = 1'b1;
                2: io_out_ready = 1'b0;
                default: io_out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // IN source: presents the model's next value some cycles after the core asks.
    initial begin
        int cnt, tgt;
        io_in_valid = 1'b0; io_in_data = '0; cnt = 0; tgt = 0;
        forever begin
            @(posedge clk); #1;
            if (in_took && io_in_valid) begin
                io_in_valid = 1'b0;
                if (in_q.size() > 0) void'(in_q.pop_front());
            end
            if (!io_in_valid && io_in_ready && in_q.size() > 0) begin
                if (cnt == 0) tgt = (in_dly_force >= 0) ? in_dly_force : $urandom_range(0, 3);
                if (cnt >= tgt) begin
                    io_in_valid = 1'b1; io_in_data = 8'(in_q[0]); cnt = 0;
                end else cnt++;
            end
        end
    end

    task automatic load_img();
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            prog_we = 1'b1; prog_addr = 8'(i); prog_wdata = 8'(img[i]);
        end
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic start_run(input string nm, input bit do_load);
        chk({nm, "_model_ends"}, 32'(model_exec()), 1);
        if (do_load) load_img();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_halt(input string nm);
        int n = 0;
        while (!halted && n < 6000) begin @(negedge clk); n++; end
        chk({nm, "_halt_timeout"}, 32'(halted), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic end_check(input string nm);
        int nbad = 0;
        chk({nm, "_outs_left"}, exp_q.size(), 0);
        chk({nm, "_ins_left"}, in_q.size(), 0);
        chk({nm, "_illegal"}, 32'(illegal), m_ill);
        chk({nm, "_pc"}, 32'(dut.r_pc), m_pc);
        chk({nm, "_acc"}, 32'(dut.r_acc), m_acc);
        chk({nm, "_zc"}, {30'b0, dut.r_z, dut.r_c}, (m_z << 1) | m_c);
        for (int i = 0; i < 256; i++) if ({24'b0, dut.u_ram.r_mem[i]} !== ram_exp[i]) nbad++;
        chk({nm, "_ram_words_wrong"}, nbad, 0);
        img = ram_exp;
    endtask

    task automatic clear_img();
        foreach (img[i]) img[i] = 0;
    endtask

    task automatic do_reset_check(input string nm);
        reset_n = 1'b0; #1;
        chk({nm, "_halted"}, 32'(halted), 1);
        chk({nm, "_illegal"}, 32'(illegal), 0);
        chk({nm, "_out_valid"}, 32'(io_out_valid), 0);
        chk({nm, "_in_ready"}, 32'(io_in_ready), 0);
        chk({nm, "_out_data"}, 32'(io_out_data), 0);
        chk({nm, "_acc"}, 32'(dut.r_acc), 0);
        m_acc = 0; m_z = 1; m_c = 0; m_pc = 0; m_ill = 0;
        exp_q.delete(); in_q.delete();
        @(posedge clk); #2 reset_n = 1'b1;
    endtask

    logic [15:0] p2 [6] = '{16'h0001, 16'h0001, 16'h0004, 16'hFFFF, 16'h000C, 16'h000F};

    initial begin
        int n;
        bit ok, seen;
        logic [15:0] got;
        reset_n = 1'b0; start = 0; prog_we = 0; prog_addr = '0; prog_wdata = '0;
        b_start = 0; b_prog_we = 0; b_prog_addr = '0; b_prog_wdata = '0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_halted", 32'(halted), 1);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_io", {29'b0, io_in_ready, io_out_valid, 1'b0}, 0);
        chk("rst_out_data", 32'(io_out_data), 0);
        chk("rst_pc_acc", {dut.r_pc, dut.r_acc}, 0);
        chk("rst_zc", {30'b0, dut.r_z, dut.r_c}, 2);

        // Load/add/out/halt with the sink always ready.
        clear_img();
        img[0] = 8'h01; img[1] = 8'h0A; img[2] = 8'h04; img[3] = 8'h05; img[4] = 8'h0C; img[5] = 8'h0F;
        rdy_force = 1;
        start_run("t1", 1); wait_halt("t1"); end_check("t1");
        chk("t1_out_const", 32'(io_out_data), 8'h0F);
        chk("t1_pc_const", 32'(dut.r_pc), 6);

        // Carry out of ADD drives JC; SUB to zero drives JZ.
        clear_img();
        img[0] = 8'h01; img[1] = 8'hF0; img[2] = 8'h04; img[3] = 8'h20; img[4] = 8'h0D; img[5] = 8'h10;
        img[8'h10] = 8'h0C; img[8'h11] = 8'h06; img[8'h12] = 8'h10; img[8'h13] = 8'h09;
        img[8'h14] = 8'h20; img[8'h15] = 8'h0F; img[8'h20] = 8'h0C; img[8'h21] = 8'h0F;
        start_run("t2", 1); wait_halt("t2"); end_check("t2");
        chk("t2_acc_const", 32'(dut.r_acc), 0);
        chk("t2_pc_const", 32'(dut.r_pc), 8'h22);

        // OUT back-pressure then late IN.
        clear_img();
        img[0] = 8'h01; img[1] = 8'h5A; img[2] = 8'h0C; img[3] = 8'h0B; img[4] = 8'h0C; img[5] = 8'h0F;
        rdy_force = 2; in_dly_force = 3;
        start_run("t3", 1);
        n = 0;
        while (!io_out_valid && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", 32'(io_out_valid), 1);
            chk("t3_hold_data", 32'(io_out_data), 8'h5A);
            chk("t3_hold_pc", 32'(dut.r_pc), 2);
            if (k == 4) rdy_force = 1;
            @(negedge clk);
        end
        wait_halt("t3"); end_check("t3");
        in_dly_force = -1;

        // Undefined opcode traps; program writes are blocked while running.
        clear_img();
        img[7] = 8'h1F; img[8'h40] = 8'h33;
        start_run("t4", 1);
        prog_we = 1'b1; prog_addr = 8'h40; prog_wdata = 8'hAA;
        @(posedge clk); #1 prog_we = 1'b0;
        wait_halt("t4"); end_check("t4");
        chk("t4_illegal_const", 32'(illegal), 1);
        chk("t4_pc_const", 32'(dut.r_pc), 7);
        chk("t4_ram_protect", 32'(dut.u_ram.r_mem[8'h40]), 8'h33);

        // Reset in the middle of ADD m, then in the middle of a stalled OUT.
        clear_img();
        img[0] = 8'h01; img[1] = 8'h03; img[2] = 8'h05; img[3] = 8'h30; img[4] = 8'h0C; img[5] = 8'h0F;
        img[8'h30] = 8'h04;
        start_run("t5a", 1);
        n = 0;
        while (dut.r_state != ST_MEMRD && n < 50) begin @(negedge clk); n++; end
        chk("t5_reached_memrd", 32'(dut.r_state), 32'(ST_MEMRD));
        do_reset_check("t5_rst_memrd");
        start_run("t5b", 0); wait_halt("t5b"); end_check("t5b");
        chk("t5b_acc_const", 32'(dut.r_acc), 7);
        rdy_force = 2;
        start_run("t5c", 0);
        n = 0;
        while (!io_out_valid && n < 50) begin @(negedge clk); n++; end
        chk("t5_out_pending", 32'(io_out_valid), 1);
        do_reset_check("t5_rst_out");
        rdy_force = 0;
        start_run("t5d", 0); wait_halt("t5d"); end_check("t5d");

        // Operand fetch wraps from 0xFF to 0x00.
        clear_img();
        img[0] = 8'h08; img[1] = 8'hFF; img[8'hFF] = 8'h01;
        start_run("t6", 1); wait_halt("t6"); end_check("t6");
        chk("t6_acc_const", 32'(dut.r_acc), 8'h08);
        chk("t6_pc_const", 32'(dut.r_pc), 1);

        // Random programs with random handshake timing.
        for (int r = 0; r < 20; r++) begin
            ok = 0;
            for (int t = 0; t < 50 && !ok; t++) begin
                foreach (img[i])
                    img[i] = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 15) : $urandom_range(0, 255);
                ok = model_exec();
            end
            if (ok) begin
                load_img();
                @(posedge clk); #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                wait_halt("rnd"); end_check("rnd");
            end
        end

        // Wide configuration: 16-bit ADD wraps to zero with carry.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            b_prog_we = 1'b1; b_prog_addr = 10'(i); b_prog_wdata = p2[i];
        end
        @(posedge clk); #1 b_prog_we = 1'b0; b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        n = 0; seen = 0; got = 16'hDEAD;
        while (!b_halted && n < 100) begin
            @(negedge clk); n++;
            if (b_io_out_valid && b_io_out_ready) begin seen = 1; got = b_io_out_data; end
        end
        chk("w16_halted", 32'(b_halted), 1);
        chk("w16_out_seen", 32'(seen), 1);
        chk("w16_out_data", 32'(got), 0);
        chk("w16_acc", 32'(dut2.r_acc), 0);
        chk("w16_zc", {30'b0, dut2.r_z, dut2.r_c}, 3);
        chk("w16_illegal", 32'(b_illegal), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
